mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter_beat_counter.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared encodings for the ICache/DCache memory arbiter |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_BUSY_I = 2'b01,
    ST_BUSY_D = 2'b10
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned DEFAULT_BURST_LEN = 16;

  // prefer_d breaks a tie in favour of the DCache.
  function automatic logic pick_winner(input logic i_req, input logic d_req, input logic prefer_d);
    if (d_req && (!i_req || prefer_d)) return PORT_D;
    return PORT_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_if.sv
// +------------------------------------------------------------------+
// | mem_bus_arbiter_if : cache-side and memory-side arbiter signals    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

interface mem_bus_arbiter_if #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    i_ce, d_ce;
  logic                    i_we, d_we;
  logic [BUS_WIDTH-1:0]    i_addr, d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_wmask;
  logic                    i_gnt, d_gnt;
  logic [DATA_WIDTH-1:0]   i_rdata, d_rdata;
  logic                    i_rdata_valid, d_rdata_valid;
  logic                    d_write_respone;
  logic                    i_done, d_done;
  logic [BUS_WIDTH-1:0]    mem_addr;
  logic                    mem_ce, mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wmask;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_rdata_valid, mem_write_respone;

  modport slave (
    input  i_ce, d_ce, i_we, d_we, i_addr, d_addr, d_wdata, d_wmask,
           mem_rdata, mem_rdata_valid, mem_write_respone,
    output i_gnt, d_gnt, i_rdata, d_rdata, i_rdata_valid, d_rdata_valid,
           d_write_respone, i_done, d_done,
           mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
  );

  modport master (
    output i_ce, d_ce, i_we, d_we, i_addr, d_addr, d_wdata, d_wmask,
           mem_rdata, mem_rdata_valid, mem_write_respone,
    input  i_gnt, d_gnt, i_rdata, d_rdata, i_rdata_valid, d_rdata_valid,
           d_write_respone, i_done, d_done,
           mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
  );

endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter_beat_counter.sv
// +------------------------------------------------------------------+
// | mem_beat_counter : per-burst beat counter with terminal-beat flag  |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module mem_beat_counter #(
  parameter int BURST_LEN = 16
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         clear,
  input  wire logic                         inc,
  output logic                              last,
  output logic [$clog2(BURST_LEN):0]        count
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)    count_d = '0;
    else if (inc) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  // Asserted during the cycle that carries the final beat of the burst.
  assign last  = inc && !clear && (count_q == CNT_W'(BURST_LEN - 1));
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +------------------------------------------------------------------+
// | mem_bus_arbiter : ICache/DCache arbiter for one burst memory port  |
// | Option macro: ARB_ROUND_ROBIN_EN (else fixed DCache priority)      |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = DEFAULT_BURST_LEN
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_bus_arbiter_if.slave  bus
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(BURST_LEN) + 1;

  state_e state_q, state_d;
  logic   winner, prefer_d;
  logic   busy_i, busy_d;
  logic   beat_inc, beat_last, beat_clear;
  logic [CNT_W-1:0] unused_beat_cnt;

  logic [BUS_WIDTH-1:0]  addr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;
  logic [MASK_W-1:0]     wmask_sel;
  logic                  we_sel;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt_q, last_gnt_d;
  always_comb begin
    prefer_d   = (last_gnt_q == PORT_I);
    last_gnt_d = last_gnt_q;
    if (state_q == ST_IDLE && (bus.i_ce || bus.d_ce)) last_gnt_d = winner;
  end
`else
  always_comb prefer_d = 1'b1;
`endif

  always_comb begin
    winner  = pick_winner(bus.i_ce, bus.d_ce, prefer_d);
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (bus.i_ce || bus.d_ce) state_d = (winner == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
      ST_BUSY_I, ST_BUSY_D:
        if (beat_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= PORT_I;
`endif
    end else begin
      state_q    <= state_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign busy_i = (state_q == ST_BUSY_I);
  assign busy_d = (state_q == ST_BUSY_D);

  // ICache is read-only: its we is ignored, so only DCache can count write responses.
  assign beat_clear = (state_q == ST_IDLE);
  assign beat_inc   = (busy_i && bus.mem_rdata_valid)
                   || (busy_d && !bus.d_we && bus.mem_rdata_valid)
                   || (busy_d &&  bus.d_we && bus.mem_write_respone);

  mem_beat_counter #(.BURST_LEN(BURST_LEN)) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .clear (beat_clear),
    .inc   (beat_inc),
    .last  (beat_last),
    .count (unused_beat_cnt)
  );

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    wmask_sel = '0;
    we_sel    = 1'b0;
    if (busy_i) begin
      addr_sel = bus.i_addr;
    end else if (busy_d) begin
      addr_sel  = bus.d_addr;
      wdata_sel = bus.d_wdata;
      wmask_sel = bus.d_wmask;
      we_sel    = bus.d_we;
    end
  end

  always_comb begin
    bus.mem_ce          = busy_i || busy_d;
    bus.mem_we          = we_sel;
    bus.mem_addr        = addr_sel;
    bus.mem_wdata       = wdata_sel;
    bus.mem_wmask       = wmask_sel;
    bus.i_gnt           = busy_i;
    bus.d_gnt           = busy_d;
    bus.i_rdata         = busy_i ? bus.mem_rdata : '0;
    bus.d_rdata         = busy_d ? bus.mem_rdata : '0;
    bus.i_rdata_valid   = busy_i && bus.mem_rdata_valid;
    bus.d_rdata_valid   = busy_d && !bus.d_we && bus.mem_rdata_valid;
    bus.d_write_respone = busy_d && bus.d_we && bus.mem_write_respone;
    bus.i_done          = busy_i && beat_last;
    bus.d_done          = busy_d && beat_last;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +------------------------------------------------------------------+
// | tb_mem_bus_arbiter : scoreboard bench for mem_bus_arbiter          |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int BL = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) bus();

  mem_bus_arbiter #(.BUS_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(BL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        port;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic model_last_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every forwarded beat or done pulse must match the head of the scoreboard.
  exp_t        mon_e;
  logic [63:0] mon_act, mon_exp;
  logic [31:0] mon_data;
  logic        mon_port, mon_other_zero;
  always @(negedge clk) begin
    if (reset === 1'b1 && (bus.i_rdata_valid || bus.d_rdata_valid || bus.d_write_respone
                           || bus.i_done || bus.d_done)) begin
      mon_port       = bus.d_rdata_valid || bus.d_write_respone;
      mon_data       = bus.d_write_respone ? bus.mem_wdata : (mon_port ? bus.d_rdata : bus.i_rdata);
      mon_other_zero = mon_port ? (bus.i_rdata == 32'h0) : (bus.d_rdata == 32'h0);
      mon_act = {23'h0, mon_port, bus.d_write_respone, mon_data,
                 bus.d_write_respone ? bus.mem_wmask : 4'h0, bus.d_done, bus.i_done, mon_other_zero};
      if (q.size() == 0) begin
        check("unexpected_beat", mon_act, 64'h0);
      end else begin
        mon_e   = q.pop_front();
        mon_exp = {23'h0, mon_e.port, mon_e.wr, mon_e.data, mon_e.wr ? mon_e.mask : 4'h0,
                   mon_e.last & mon_e.port, mon_e.last & ~mon_e.port, 1'b1};
        check("beat", mon_act, mon_exp);
      end
    end
  end

  function automatic logic model_winner(input logic i_req, input logic d_req);
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) return ~model_last_gnt;
`else
    if (i_req && d_req) return PORT_D;
`endif
    return d_req ? PORT_D : PORT_I;
  endfunction

  task automatic beat(input logic port, input logic wr, input int b, input logic last);
    exp_t        e;
    logic [3:0]  bb;
    logic [31:0] data;
    bb   = b[3:0];
    data = 32'hA500_0000 ^ (32'(b) * 32'h0001_0203) ^ {31'h0, port};
    if (wr) begin
      bus.d_wdata           = data;
      bus.d_wmask           = bb ^ 4'h5;
      bus.mem_write_respone = 1'b1;
    end else begin
      bus.mem_rdata       = data;
      bus.mem_rdata_valid = 1'b1;
    end
    e.port = port; e.wr = wr; e.data = data; e.mask = bb ^ 4'h5; e.last = last;
    q.push_back(e);
    @(posedge clk); #1;
    bus.mem_rdata_valid   = 1'b0;
    bus.mem_write_respone = 1'b0;
    bus.mem_rdata         = 32'hDEAD_BEEF;
  endtask

  // Called in an IDLE cycle with the requests already raised; returns in the turnaround cycle.
  task automatic do_burst(input int gap, input logic drop_ce);
    logic        port, wr;
    logic [31:0] addr;
    port = model_winner(bus.i_ce, bus.d_ce);
    wr   = port & bus.d_we;
    addr = port ? bus.d_addr : bus.i_addr;
    model_last_gnt = port;
    @(posedge clk); #1;
    check("gnt", {62'h0, bus.i_gnt, bus.d_gnt}, port ? 64'h1 : 64'h2);
    check("mem_ce", {63'h0, bus.mem_ce}, 64'h1);
    check("mem_addr", {32'h0, bus.mem_addr}, {32'h0, addr});
    check("mem_we", {63'h0, bus.mem_we}, {63'h0, wr});
    for (int b = 0; b < BL; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      if (b == BL - 1 && drop_ce) begin
        if (port) bus.d_ce = 1'b0;
        else      bus.i_ce = 1'b0;
      end
      beat(port, wr, b, b == BL - 1);
    end
    check("idle_mem_ce", {63'h0, bus.mem_ce}, 64'h0);
    check("idle_gnt", {62'h0, bus.i_gnt, bus.d_gnt}, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.i_ce = 0; bus.d_ce = 0; bus.i_we = 0; bus.d_we = 0;
    bus.i_addr = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wmask = 0;
    bus.mem_rdata = 0; bus.mem_rdata_valid = 0; bus.mem_write_respone = 0;
    model_last_gnt = PORT_I;

    // Reset state, with a request pending that must not leak through.
    bus.d_ce = 1'b1; bus.d_addr = 32'h0000_2000; bus.d_wdata = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {62'h0, bus.i_gnt, bus.d_gnt}, 64'h0);
    check("rst_mem_ce", {63'h0, bus.mem_ce}, 64'h0);
    check("rst_mem_addr", {32'h0, bus.mem_addr}, 64'h0);
    check("rst_mem_wdata", {32'h0, bus.mem_wdata}, 64'h0);
    bus.d_ce = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single ICache read burst.
    bus.i_ce = 1'b1; bus.i_addr = 32'h0000_1000;
    do_burst(0, 1'b1);

    // Tie: DCache first, then ICache (with i_we=1 treated as read).
    bus.i_ce = 1'b1; bus.i_addr = 32'h0000_3000; bus.i_we = 1'b1;
    bus.d_ce = 1'b1; bus.d_addr = 32'h0000_2000; bus.d_we = 1'b0;
    do_burst(0, 1'b1);
    do_burst(0, 1'b1);
    bus.i_we = 1'b0;

    // DCache write burst, response every other cycle.
    bus.d_ce = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_4000;
    do_burst(1, 1'b1);
    bus.d_we = 1'b0;

    // Stray responses in IDLE must be dropped and not counted.
    for (int k = 0; k < 3; k++) begin
      bus.mem_rdata_valid = 1'b1; bus.mem_write_respone = 1'b1; bus.mem_rdata = 32'hBAD0_0000;
      #1;
      check("stray_fwd", {61'h0, bus.i_rdata_valid, bus.d_rdata_valid, bus.d_write_respone}, 64'h0);
      @(posedge clk); #1;
    end
    bus.mem_rdata_valid = 1'b0; bus.mem_write_respone = 1'b0;
    bus.d_ce = 1'b1; bus.d_addr = 32'h0000_5000;
    do_burst(0, 1'b1);

    // Reset in the middle of an ICache read.
    bus.i_ce = 1'b1; bus.i_addr = 32'h0000_6000;
    @(posedge clk); #1;
    check("pre_rst_gnt", {62'h0, bus.i_gnt, bus.d_gnt}, 64'h2);
    for (int b = 0; b < 7; b++) beat(PORT_I, 1'b0, b, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_mem_ce", {63'h0, bus.mem_ce}, 64'h0);
    check("midrst_i_gnt", {63'h0, bus.i_gnt}, 64'h0);
    bus.i_ce = 1'b0;
    model_last_gnt = PORT_I;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    bus.d_ce = 1'b1; bus.d_addr = 32'h0000_7000;
    do_burst(0, 1'b1);

    // Both held: fixed priority starves ICache, round-robin alternates.
    bus.i_ce = 1'b1; bus.i_addr = 32'h0000_8000;
    bus.d_ce = 1'b1; bus.d_addr = 32'h0000_9000;
    for (int r = 0; r < 4; r++) do_burst(0, 1'b0);
    bus.i_ce = 1'b0; bus.d_ce = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("final_idle_gnt", {62'h0, bus.i_gnt, bus.d_gnt}, 64'h0);

    check("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
